// File: rtl/fpga_rf_wb_queue.sv
// Write-side staging queue for the 7R1W register-file RAM: merges two writeback
// sources into one write port, drains in arrival order and forwards pending data.

module fpga_rf_wb_queue #(
    parameter int WIDTH = 32,
    parameter int AW    = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb0_valid,
    output logic             wb0_ready,
    input  logic [AW-1:0]    wb0_addr,
    input  logic [WIDTH-1:0] wb0_data,
    input  logic             wb1_valid,
    output logic             wb1_ready,
    input  logic [AW-1:0]    wb1_addr,
    input  logic [WIDTH-1:0] wb1_data,
    output logic [AW-1:0]    addrw,
    output logic [WIDTH-1:0] din,
    output logic             wea,
    input  logic [AW-1:0]    qaddr,
    output logic             qhit,
    output logic [WIDTH-1:0] qdata,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             r_wea;
    logic             r_empty;
    logic             r_rdy0;
    logic             r_rdy1;
    logic [AW-1:0]    r_addr [DEPTH];
    logic [WIDTH-1:0] r_data [DEPTH];

    logic             w_push0;
    logic             w_push1;
    logic             w_pop;
    logic [PW-1:0]    w_slot1;
    logic [CW-1:0]    w_count_next;
    logic [CW-1:0]    w_free_next;
    logic             w_qhit;
    logic [WIDTH-1:0] w_qdata;

    // Accept decisions and next occupancy; readiness depends only on registered state.
    always_comb begin
        w_push0      = wb0_valid & r_rdy0;
        w_push1      = wb1_valid & r_rdy1;
        w_pop        = r_wea;
        w_slot1      = r_wr_ptr + PW'(w_push0);
        w_count_next = r_count + CW'(w_push0) + CW'(w_push1) - CW'(w_pop);
        w_free_next  = CW'(DEPTH) - w_count_next;
    end

    // Pointer, occupancy and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= {PW{1'b0}};
            r_wr_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
            r_wea    <= 1'b0;
            r_empty  <= 1'b1;
            r_rdy0   <= 1'b1;
            r_rdy1   <= 1'b1;
        end else begin
            r_rd_ptr <= r_rd_ptr + PW'(w_pop);
            r_wr_ptr <= r_wr_ptr + PW'(w_push0) + PW'(w_push1);
            r_count  <= w_count_next;
            r_wea    <= (w_count_next != {CW{1'b0}});
            r_empty  <= (w_count_next == {CW{1'b0}});
            r_rdy0   <= (w_free_next >= CW'(1));
            r_rdy1   <= (w_free_next >= CW'(2));
        end
    end

    // Slot storage; contents are meaningful only while counted, so no reset.
    always_ff @(posedge clk) begin
        if (w_push0) begin
            r_addr[r_wr_ptr] <= wb0_addr;
            r_data[r_wr_ptr] <= wb0_data;
        end
        if (w_push1) begin
            r_addr[w_slot1] <= wb1_addr;
            r_data[w_slot1] <= wb1_data;
        end
    end

    // Forwarding scan from oldest to youngest so the last match wins.
    always_comb begin
        logic [PW-1:0] w_idx;
        w_idx   = r_rd_ptr;
        w_qhit  = 1'b0;
        w_qdata = {WIDTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rd_ptr + PW'(i);
            if ((CW'(i) < r_count) && (r_addr[w_idx] == qaddr)) begin
                w_qhit  = 1'b1;
                w_qdata = r_data[w_idx];
            end else begin
                w_qhit  = w_qhit;
                w_qdata = w_qdata;
            end
        end
    end

    assign wb0_ready = r_rdy0;
    assign wb1_ready = r_rdy1;
    assign wea       = r_wea;
    assign empty     = r_empty;
    assign addrw     = r_addr[r_rd_ptr];
    assign din       = r_data[r_rd_ptr];
    assign qhit      = w_qhit;
    assign qdata     = w_qdata;

    fpga_rf_wb_queue_chk #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .count     (r_count),
        .wb0_ready (r_rdy0),
        .wb1_ready (r_rdy1),
        .wea       (r_wea),
        .empty     (r_empty)
    );

endmodule

// Invariant checker bound into the queue.
module fpga_rf_wb_queue_chk #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input logic          clk,
    input logic          rst_n,
    input logic [CW-1:0] count,
    input logic          wb0_ready,
    input logic          wb1_ready,
    input logic          wea,
    input logic          empty
);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        count <= CW'(DEPTH));

    a_ready_order: assert property (@(posedge clk) disable iff (!rst_n)
        wb1_ready |-> wb0_ready);

    a_wea_empty: assert property (@(posedge clk) disable iff (!rst_n)
        wea == !empty);

endmodule

// File: tb/tb_fpga_rf_wb_queue.sv
// Self-checking bench for fpga_rf_wb_queue: directed scenarios plus a randomized
// run against a queue-of-pending-writes reference model.

module tb_fpga_rf_wb_queue;

    localparam int WIDTH = 32;
    localparam int AW    = 6;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wb0_valid = 1'b0, wb1_valid = 1'b0;
    logic             wb0_ready, wb1_ready;
    logic [AW-1:0]    wb0_addr = '0, wb1_addr = '0, qaddr = '0;
    logic [WIDTH-1:0] wb0_data = '0, wb1_data = '0;
    logic [AW-1:0]    addrw;
    logic [WIDTH-1:0] din, qdata;
    logic             wea, qhit, empty;

    int n_vec = 0;
    int n_err = 0;

    // pending writes, oldest first: {addr, data}
    logic [AW+WIDTH-1:0] mq[$];
    logic [WIDTH-1:0]    ram_m   [64];
    logic [WIDTH-1:0]    ram_dut [64];

    fpga_rf_wb_queue #(.WIDTH(WIDTH), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
        .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
        .addrw(addrw), .din(din), .wea(wea),
        .qaddr(qaddr), .qhit(qhit), .qdata(qdata), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        wb0_valid = 1'b0;
        wb1_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        n_vec++; if (wea !== 1'b0) begin n_err++; $display("FAIL reset_wea: got %b expected 0", wea); end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b expected 1", empty); end
        n_vec++; if (wb0_ready !== 1'b1) begin n_err++; $display("FAIL reset_rdy0: got %b expected 1", wb0_ready); end
        n_vec++; if (wb1_ready !== 1'b1) begin n_err++; $display("FAIL reset_rdy1: got %b expected 1", wb1_ready); end
        n_vec++; if (qhit !== 1'b0) begin n_err++; $display("FAIL reset_qhit: got %b expected 0", qhit); end
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
    endtask

    task automatic test_single();
        @(negedge clk);
        wb0_valid = 1'b1; wb0_addr = 6'd5; wb0_data = 32'h0000_00A5;
        @(negedge clk);
        idle_inputs();
        #1;
        n_vec++; if (wea !== 1'b1) begin n_err++; $display("FAIL single_wea: got %b expected 1", wea); end
        n_vec++; if (addrw !== 6'd5) begin n_err++; $display("FAIL single_addrw: got %0d expected 5", addrw); end
        n_vec++; if (din !== 32'h0000_00A5) begin n_err++; $display("FAIL single_din: got %h expected 000000a5", din); end
        @(negedge clk);
        #1;
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL single_empty: got %b expected 1", empty); end
        n_vec++; if (wea !== 1'b0) begin n_err++; $display("FAIL single_wea_off: got %b expected 0", wea); end
    endtask

    task automatic test_same_addr();
        @(negedge clk);
        wb0_valid = 1'b1; wb0_addr = 6'd3; wb0_data = 32'h0000_0011;
        wb1_valid = 1'b1; wb1_addr = 6'd3; wb1_data = 32'h0000_0022;
        qaddr = 6'd3;
        @(negedge clk);
        idle_inputs();
        #1;
        n_vec++; if (qhit !== 1'b1) begin n_err++; $display("FAIL same_qhit1: got %b expected 1", qhit); end
        n_vec++; if (qdata !== 32'h0000_0022) begin n_err++; $display("FAIL same_qdata1: got %h expected 00000022", qdata); end
        n_vec++; if (wea !== 1'b1) begin n_err++; $display("FAIL same_wea1: got %b expected 1", wea); end
        n_vec++; if (addrw !== 6'd3) begin n_err++; $display("FAIL same_addrw1: got %0d expected 3", addrw); end
        n_vec++; if (din !== 32'h0000_0011) begin n_err++; $display("FAIL same_din1: got %h expected 00000011", din); end
        @(negedge clk);
        #1;
        n_vec++; if (din !== 32'h0000_0022) begin n_err++; $display("FAIL same_din2: got %h expected 00000022", din); end
        n_vec++; if (qdata !== 32'h0000_0022) begin n_err++; $display("FAIL same_qdata2: got %h expected 00000022", qdata); end
        @(negedge clk);
        #1;
        n_vec++; if (qhit !== 1'b0) begin n_err++; $display("FAIL same_qhit3: got %b expected 0", qhit); end
        n_vec++; if (qdata !== 32'h0) begin n_err++; $display("FAIL same_qdata3: got %h expected 0", qdata); end
    endtask

    task automatic test_back_to_back();
        int  next = 0;
        int  exp_wr = 0;
        int  cyc = 0;
        bit  r0m, r1m, acc0, acc1;
        bit  saw_r1_low = 1'b0;
        mq.delete();
        while (exp_wr < 8 && cyc < 40) begin
            @(negedge clk);
            r0m = (mq.size() < DEPTH);
            r1m = (mq.size() + 2 <= DEPTH);
            wb0_valid = (next < 8);     wb0_addr = AW'(next);     wb0_data = WIDTH'(next);
            wb1_valid = (next + 1 < 8); wb1_addr = AW'(next + 1); wb1_data = WIDTH'(next + 1);
            #1;
            n_vec++; if (wb0_ready !== r0m) begin n_err++; $display("FAIL b2b_rdy0 cyc %0d: got %b expected %b", cyc, wb0_ready, r0m); end
            n_vec++; if (wb1_ready !== r1m) begin n_err++; $display("FAIL b2b_rdy1 cyc %0d: got %b expected %b", cyc, wb1_ready, r1m); end
            if (wb1_ready === 1'b0) saw_r1_low = 1'b1;
            if (mq.size() > 0) begin
                n_vec++;
                if (wea !== 1'b1 || addrw !== AW'(exp_wr)) begin
                    n_err++; $display("FAIL b2b_write cyc %0d: got wea=%b addr=%0d expected wea=1 addr=%0d", cyc, wea, addrw, exp_wr);
                end
                exp_wr++;
            end
            acc0 = wb0_valid && r0m;
            acc1 = wb1_valid && r1m;
            @(posedge clk);
            if (mq.size() > 0) void'(mq.pop_front());
            if (acc0) mq.push_back({wb0_addr, wb0_data});
            if (acc1) mq.push_back({wb1_addr, wb1_data});
            next += int'(acc0) + int'(acc1);
            cyc++;
        end
        idle_inputs();
        n_vec++; if (exp_wr != 8) begin n_err++; $display("FAIL b2b_count: got %0d writes expected 8", exp_wr); end
        n_vec++; if (saw_r1_low !== 1'b1) begin n_err++; $display("FAIL b2b_rdy1_drop: got %b expected 1", saw_r1_low); end
        repeat (DEPTH + 1) @(negedge clk);
        #1;
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL b2b_drained: got %b expected 1", empty); end
        mq.delete();
    endtask

    task automatic test_reset_mid();
        qaddr = 6'd12;
        @(negedge clk);
        wb0_valid = 1'b1; wb0_addr = 6'd10; wb0_data = 32'hAAAA_0010;
        wb1_valid = 1'b1; wb1_addr = 6'd11; wb1_data = 32'hAAAA_0011;
        @(negedge clk);
        wb0_addr = 6'd12; wb0_data = 32'hAAAA_0012;
        wb1_addr = 6'd13; wb1_data = 32'hAAAA_0013;
        @(posedge clk);
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (wea !== 1'b0) begin n_err++; $display("FAIL rmid_wea: got %b expected 0", wea); end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL rmid_empty: got %b expected 1", empty); end
        n_vec++; if (qhit !== 1'b0) begin n_err++; $display("FAIL rmid_qhit: got %b expected 0", qhit); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            n_vec++; if (wea !== 1'b0) begin n_err++; $display("FAIL rmid_stale %0d: got wea=%b expected 0", k, wea); end
        end
        mq.delete();
    endtask

    task automatic test_random(input int cycles);
        bit               r0m, r1m, acc0, acc1, m_hit;
        logic [WIDTH-1:0] m_data;
        logic [AW+WIDTH-1:0] head;
        for (int a = 0; a < 64; a++) begin ram_m[a] = '0; ram_dut[a] = '0; end
        mq.delete();
        for (int c = 0; c < cycles + DEPTH + 2; c++) begin
            @(negedge clk);
            if (c < cycles) begin
                wb0_valid = ($urandom % 4) != 0;
                wb1_valid = ($urandom % 3) != 0;
            end else begin
                idle_inputs();
            end
            wb0_addr = AW'($urandom_range(0, 7)); wb0_data = $urandom;
            wb1_addr = AW'($urandom_range(0, 7)); wb1_data = $urandom;
            qaddr    = AW'($urandom_range(0, 7));
            #1;
            r0m = (mq.size() < DEPTH);
            r1m = (mq.size() + 2 <= DEPTH);
            m_hit = 1'b0; m_data = '0;
            foreach (mq[k]) if (mq[k][AW+WIDTH-1:WIDTH] == qaddr) begin m_hit = 1'b1; m_data = mq[k][WIDTH-1:0]; end
            n_vec++; if (wb0_ready !== r0m) begin n_err++; $display("FAIL rnd_rdy0 c%0d: got %b expected %b", c, wb0_ready, r0m); end
            n_vec++; if (wb1_ready !== r1m) begin n_err++; $display("FAIL rnd_rdy1 c%0d: got %b expected %b", c, wb1_ready, r1m); end
            n_vec++; if (wea !== (mq.size() != 0)) begin n_err++; $display("FAIL rnd_wea c%0d: got %b expected %b", c, wea, mq.size() != 0); end
            n_vec++; if (empty !== (mq.size() == 0)) begin n_err++; $display("FAIL rnd_empty c%0d: got %b expected %b", c, empty, mq.size() == 0); end
            if (mq.size() != 0) begin
                head = mq[0];
                n_vec++;
                if (addrw !== head[AW+WIDTH-1:WIDTH] || din !== head[WIDTH-1:0]) begin
                    n_err++; $display("FAIL rnd_write c%0d: got %0d/%h expected %0d/%h", c, addrw, din, head[AW+WIDTH-1:WIDTH], head[WIDTH-1:0]);
                end
            end
            n_vec++; if (qhit !== m_hit) begin n_err++; $display("FAIL rnd_qhit c%0d: got %b expected %b", c, qhit, m_hit); end
            n_vec++; if (qdata !== m_data) begin n_err++; $display("FAIL rnd_qdata c%0d: got %h expected %h", c, qdata, m_data); end
            if (wea === 1'b1) ram_dut[addrw] = din;
            acc0 = wb0_valid && r0m;
            acc1 = wb1_valid && r1m;
            @(posedge clk);
            if (mq.size() > 0) begin
                head = mq.pop_front();
                ram_m[head[AW+WIDTH-1:WIDTH]] = head[WIDTH-1:0];
            end
            if (acc0) mq.push_back({wb0_addr, wb0_data});
            if (acc1) mq.push_back({wb1_addr, wb1_data});
        end
        for (int a = 0; a < 8; a++) begin
            n_vec++; if (ram_dut[a] !== ram_m[a]) begin n_err++; $display("FAIL rnd_ram[%0d]: got %h expected %h", a, ram_dut[a], ram_m[a]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_same_addr();
        test_back_to_back();
        test_reset_mid();
        test_random(10000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
